time_of_day_counter: RTL and testbench

//   Consumes the one-clk-wide 1 Hz tick from the frequency divider and keeps

---
 rtl/clock_pkg.sv | 36 +++
 rtl/bcd_mod_counter.sv | 53 +++++
 rtl/time_of_day_counter.sv | 157 +++++++++++++++
 tb/tb_time_of_day_counter.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared constants and helpers for the time-of-day counter.
// Everything is kept as two-digit BCD, {tens, units}, so the values can go
// straight to the display stage without any binary-to-BCD conversion.
// The handshake FSM state encodings also live here so they can be used by any
// other block that needs to follow the load protocol.
package clock_pkg;

    localparam int BCD_W = 8;
    typedef logic [BCD_W-1:0] bcd_t;

    localparam bcd_t SEC_MAX = 8'h59;
    localparam bcd_t MIN_MAX = 8'h59;

    // Hour ranges for the two supported day lengths
    localparam bcd_t HOUR_MIN_24 = 8'h00;
    localparam bcd_t HOUR_MAX_24 = 8'h23;
    localparam bcd_t HOUR_MIN_12 = 8'h01;
    localparam bcd_t HOUR_MAX_12 = 8'h12;

    // In 12-hour mode the day starts when the display rolls 11 -> 12
    localparam bcd_t HOUR_LAST_12 = 8'h11;

    // Load handshake states. WAIT only exists right after reset so that
    // set_ready stays low for that first cycle.
    localparam logic [1:0] ST_WAIT   = 2'd0;
    localparam logic [1:0] ST_IDLE   = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;

    // Both digits must be decimal, and the whole value no larger than max.
    // BCD values order the same way as their decimal meaning, so a plain
    // unsigned compare against a BCD limit is correct.
    function automatic logic is_bcd_legal(input bcd_t value, input bcd_t max);
        return (value[3:0] <= 4'd9) && (value[7:4] <= 4'd9) && (value <= max);
    endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter that runs MIN_VAL..MAX_VAL and wraps back to MIN_VAL.
// Used for the seconds, minutes and hours fields of the time-of-day counter.
//
// Ports:
//   clk       in   system clock
//   reset     in   asynchronous active-high reset, value -> RESET_VAL
//   inc       in   advance by one this cycle
//   load      in   overwrite with load_val this cycle (wins over inc)
//   load_val  in   BCD value to load
//   value     out  current BCD value (registered)
//   wrap      out  combinational: this cycle's increment rolls MAX_VAL -> MIN_VAL
module bcd_mod_counter
    import clock_pkg::*;
#(
    parameter bcd_t MIN_VAL   = 8'h00,
    parameter bcd_t MAX_VAL   = 8'h59,
    parameter bcd_t RESET_VAL = MIN_VAL
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic load,
    input  bcd_t load_val,
    output bcd_t value,
    output logic wrap
);

    bcd_t next_val;

    always_comb begin
        next_val = value;
        if (value == MAX_VAL) begin
            next_val = MIN_VAL;
        end else if (value[3:0] == 4'd9) begin
            next_val = {value[7:4] + 4'd1, 4'd0};
        end else begin
            next_val = {value[7:4], value[3:0] + 4'd1};
        end
    end

    assign wrap = inc && !load && (value == MAX_VAL);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value <= RESET_VAL;
        end else if (load) begin
            value <= load_val;
        end else if (inc) begin
            value <= next_val;
        end
    end

endmodule

// File: rtl/time_of_day_counter.sv
// Time-of-day counter: takes the 1 Hz tick from the frequency divider and
// keeps BCD hours/minutes/seconds for the display multiplexer. HH:MM can be
// loaded through a valid/ready handshake, and the debounced buttons step
// minutes or hours by one.
//
// Ports:
//   clk          in   system clock
//   reset        in   asynchronous active-high reset
//   tick         in   one-cycle pulse per second
//   set_valid    in   load request, qualifies set_hours/set_minutes
//   set_ready    out  a load can be accepted this cycle
//   set_hours    in   BCD hours to load
//   set_minutes  in   BCD minutes to load
//   set_err      out  pulse: the accepted load was not a legal time, dropped
//   inc_min      in   pulse: minutes +1, never carries into hours
//   inc_hour     in   pulse: hours +1, never raises day_tick
//   hours        out  BCD hours
//   minutes      out  BCD minutes
//   seconds      out  BCD seconds
//   min_tick     out  pulse when seconds roll 59 -> 00 on a tick
//   day_tick     out  pulse when a tick carries the clock into a new day
//
// HOURS_PER_DAY selects 24 (00..23) or 12 (01..12); any value other than 12
// behaves as 24.
module time_of_day_counter
    import clock_pkg::*;
#(
    parameter int HOURS_PER_DAY = 24
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       set_valid,
    output logic       set_ready,
    input  logic [7:0] set_hours,
    input  logic [7:0] set_minutes,
    output logic       set_err,
    input  logic       inc_min,
    input  logic       inc_hour,
    output logic [7:0] hours,
    output logic [7:0] minutes,
    output logic [7:0] seconds,
    output logic       min_tick,
    output logic       day_tick
);

    localparam bit   MODE_12    = (HOURS_PER_DAY == 12);
    localparam bcd_t HOUR_MIN   = MODE_12 ? HOUR_MIN_12 : HOUR_MIN_24;
    localparam bcd_t HOUR_MAX   = MODE_12 ? HOUR_MAX_12 : HOUR_MAX_24;
    localparam bcd_t HOUR_RESET = MODE_12 ? HOUR_MAX_12 : HOUR_MIN_24;

    logic [1:0] state;
    logic       accept;
    logic       load_legal;
    logic       load_now;
    logic       sec_inc;
    logic       min_inc;
    logic       hour_inc;
    logic       sec_wrap;
    logic       min_wrap;
    logic       hour_wrap;
    logic       min_carry;
    logic       hour_from_tick;
    logic       day_wrap;

    assign set_ready = (state == ST_IDLE);
    assign accept    = set_valid && set_ready;

    assign load_legal = is_bcd_legal(set_minutes, MIN_MAX)
                     && is_bcd_legal(set_hours, HOUR_MAX)
                     && (set_hours >= HOUR_MIN);
    assign load_now   = accept && load_legal;

    // An accepted load, legal or not, freezes all counting for that cycle.
    // A button press on minutes takes the place of the seconds carry (so
    // minutes move once) and also swallows the carry into hours. Likewise
    // the hour button absorbs a minute carry, and a button-driven hour
    // change never counts as the start of a new day.
    assign sec_inc        = tick && !accept;
    assign min_inc        = !accept && (inc_min || sec_wrap);
    assign min_carry      = min_wrap && !inc_min;
    assign hour_inc       = !accept && (inc_hour || min_carry);
    assign hour_from_tick = min_carry && !inc_hour;

    // In 24-hour mode the new day coincides with the hour counter wrapping;
    // in 12-hour mode it is the 11 -> 12 step, not the 12 -> 01 wrap.
    assign day_wrap = hour_from_tick && (MODE_12 ? (hours == HOUR_LAST_12) : hour_wrap);

    bcd_mod_counter #(
        .MIN_VAL   (8'h00),
        .MAX_VAL   (SEC_MAX),
        .RESET_VAL (8'h00)
    ) u_seconds (
        .clk      (clk),
        .reset    (reset),
        .inc      (sec_inc),
        .load     (load_now),
        .load_val (8'h00),
        .value    (seconds),
        .wrap     (sec_wrap)
    );

    bcd_mod_counter #(
        .MIN_VAL   (8'h00),
        .MAX_VAL   (MIN_MAX),
        .RESET_VAL (8'h00)
    ) u_minutes (
        .clk      (clk),
        .reset    (reset),
        .inc      (min_inc),
        .load     (load_now),
        .load_val (set_minutes),
        .value    (minutes),
        .wrap     (min_wrap)
    );

    bcd_mod_counter #(
        .MIN_VAL   (HOUR_MIN),
        .MAX_VAL   (HOUR_MAX),
        .RESET_VAL (HOUR_RESET)
    ) u_hours (
        .clk      (clk),
        .reset    (reset),
        .inc      (hour_inc),
        .load     (load_now),
        .load_val (set_hours),
        .value    (hours),
        .wrap     (hour_wrap)
    );

    // Every accept is followed by exactly one COMMIT cycle with set_ready low,
    // which is also the cycle set_err is visible in.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_WAIT;
        end else begin
            case (state)
                ST_WAIT: state <= ST_IDLE;
                ST_IDLE: if (set_valid) state <= ST_COMMIT;
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            set_err  <= 1'b0;
            min_tick <= 1'b0;
            day_tick <= 1'b0;
        end else begin
            set_err  <= accept && !load_legal;
            min_tick <= sec_wrap;
            day_tick <= day_wrap;
        end
    end

endmodule

// File: tb/tb_time_of_day_counter.sv
// Bench for time_of_day_counter. A 24-hour and a 12-hour instance share all
// inputs. Each scenario task builds a table of per-cycle stimulus rows with
// the outputs the clock must show after that cycle; the expectation is queued
// as the row is driven and popped once the edge has been taken.
// Observed/expected words are printed as hex hhmmssF, where F = {min_tick,
// day_tick, set_err, set_ready}.
module tb_time_of_day_counter;

    logic       clk;
    logic       reset;
    logic       tick;
    logic       set_valid;
    logic [7:0] set_hours;
    logic [7:0] set_minutes;
    logic       inc_min;
    logic       inc_hour;

    logic       set_ready_24, set_err_24, min_tick_24, day_tick_24;
    logic [7:0] hours_24, minutes_24, seconds_24;
    logic       set_ready_12, set_err_12, min_tick_12, day_tick_12;
    logic [7:0] hours_12, minutes_12, seconds_12;

    logic [27:0] act_24;
    logic [27:0] act_12;

    typedef struct packed {
        logic        tick;
        logic        valid;
        logic [7:0]  sh;
        logic [7:0]  sm;
        logic        im;
        logic        ih;
        logic [27:0] want;
    } row_t;

    logic [27:0] exp_q[$];
    int tests_run;
    int tests_failed;

    assign act_24 = {hours_24, minutes_24, seconds_24, min_tick_24, day_tick_24, set_err_24, set_ready_24};
    assign act_12 = {hours_12, minutes_12, seconds_12, min_tick_12, day_tick_12, set_err_12, set_ready_12};

    time_of_day_counter #(.HOURS_PER_DAY(24)) dut_24 (
        .clk         (clk),
        .reset       (reset),
        .tick        (tick),
        .set_valid   (set_valid),
        .set_ready   (set_ready_24),
        .set_hours   (set_hours),
        .set_minutes (set_minutes),
        .set_err     (set_err_24),
        .inc_min     (inc_min),
        .inc_hour    (inc_hour),
        .hours       (hours_24),
        .minutes     (minutes_24),
        .seconds     (seconds_24),
        .min_tick    (min_tick_24),
        .day_tick    (day_tick_24)
    );

    time_of_day_counter #(.HOURS_PER_DAY(12)) dut_12 (
        .clk         (clk),
        .reset       (reset),
        .tick        (tick),
        .set_valid   (set_valid),
        .set_ready   (set_ready_12),
        .set_hours   (set_hours),
        .set_minutes (set_minutes),
        .set_err     (set_err_12),
        .inc_min     (inc_min),
        .inc_hour    (inc_hour),
        .hours       (hours_12),
        .minutes     (minutes_12),
        .seconds     (seconds_12),
        .min_tick    (min_tick_12),
        .day_tick    (day_tick_12)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] bcd(input int n);
        return {4'(n / 10), 4'(n % 10)};
    endfunction

    function automatic logic [27:0] v(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s,
                                      input logic mt, input logic dt, input logic err, input logic rdy);
        return {h, m, s, mt, dt, err, rdy};
    endfunction

    function automatic row_t r(input logic t, input logic vld, input logic [7:0] sh, input logic [7:0] sm,
                               input logic im, input logic ih, input logic [27:0] want);
        row_t x;
        x.tick  = t;
        x.valid = vld;
        x.sh    = sh;
        x.sm    = sm;
        x.im    = im;
        x.ih    = ih;
        x.want  = want;
        return x;
    endfunction

    task automatic drive_row(input row_t row);
        tick        = row.tick;
        set_valid   = row.valid;
        set_hours   = row.sh;
        set_minutes = row.sm;
        inc_min     = row.im;
        inc_hour    = row.ih;
    endtask

    task automatic clear_inputs();
        tick        = 1'b0;
        set_valid   = 1'b0;
        set_hours   = 8'h00;
        set_minutes = 8'h00;
        inc_min     = 1'b0;
        inc_hour    = 1'b0;
    endtask

    task automatic test_reset;
        row_t rows[$];
        logic [27:0] expected;
        @(posedge clk);
        #1;
        tests_run++;
        if (act_24 !== v(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0)) begin
            tests_failed++;
            $display("[TB] FAIL reset_state_24: got %h, expected %h", act_24, v(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0));
        end
        tests_run++;
        if (act_12 !== v(8'h12, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0)) begin
            tests_failed++;
            $display("[TB] FAIL reset_state_12: got %h, expected %h", act_12, v(8'h12, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0));
        end
        #2 reset = 1'b0;
        rows.push_back(r(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, v(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1)));
        for (int i = 1; i <= 3; i++)
            rows.push_back(r(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, v(8'h00, 8'h00, bcd(i), 1'b0, 1'b0, 1'b0, 1'b1)));
        rows.push_back(r(1'b0, 1'b1, 8'h01, 8'h02, 1'b0, 1'b0, v(8'h01, 8'h02, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0)));
        rows.push_back(r(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, v(8'h01, 8'h02, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1)));
        rows.push_back(r(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, v(8'h01, 8'h02, 8'h01, 1'b0, 1'b0, 1'b0, 1'b1)));
        foreach (rows[i]) begin
            drive_row(rows[i]);
            exp_q.push_back(rows[i].want);
            @(posedge clk);
            #1;
            expected = exp_q.pop_front();
            tests_run++;
            if (act_24 !== expected) begin
                tests_failed++;
                $display("[TB] FAIL reset row %0d: got %h, expected %h", i, act_24, expected);
            end
        end
        // Illegal load pending when reset hits mid-cycle: must be dropped silently
        clear_inputs();
        set_valid = 1'b1;
        set_hours = 8'h1A;
        #3 reset = 1'b1;
        #1;
        tests_run++;
        if (act_24 !== v(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0)) begin
            tests_failed++;
            $display("[TB] FAIL async_reset: got %h, expected %h", act_24, v(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0));
        end
        @(posedge clk);
        #1;
        tests_run++;
        if (act_24 !== v(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0)) begin
            tests_failed++;
            $display("[TB] FAIL reset_mid_load: got %h, expected %h", act_24, v(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0));
        end
        set_valid = 1'b0;
        #2 reset = 1'b0;
        @(posedge clk);
        #1;
        tests_run++;
        if (act_24 !== v(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1)) begin
            tests_failed++;
            $display("[TB] FAIL ready_after_reset: got %h, expected %h", act_24, v(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1));
        end
    endtask

    task automatic test_rollover;
        row_t rows[$];
        logic [27:0] expected;
        rows.push_back(r(1'b0, 1'b1, 8'h23, 8'h59, 1'b0, 1'b0, v(8'h23, 8'h59, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0)));
        for (int i = 1; i <= 59; i++)
            rows.push_back(r(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, v(8'h23, 8'h59, bcd(i), 1'b0, 1'b0, 1'b0, 1'b1)));
        rows.push_back(r(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, v(8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1)));
        rows.push_back(r(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, v(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1)));
        foreach (rows[i]) begin
            drive_row(rows[i]);
            exp_q.push_back(rows[i].want);
            @(posedge clk);
            #1;
            expected = exp_q.pop_front();
            tests_run++;
            if (act_24 !== expected) begin
                tests_failed++;
                $display("[TB] FAIL rollover row %0d: got %h, expected %h", i, act_24, expected);
            end
        end
        clear_inputs();
    endtask

    // Includes a held request: re-accepted two cycles after the first accept,
    // with a tick counted in the commit cycle and ignored in the accept cycle.
    task automatic test_load;
        row_t rows[$];
        logic [27:0] expected;
        rows.push_back(r(1'b0, 1'b1, 8'h07, 8'h10, 1'b0, 1'b0, v(8'h07, 8'h10, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0)));
        for (int i = 1; i <= 45; i++)
            rows.push_back(r(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, v(8'h07, 8'h10, bcd(i), 1'b0, 1'b0, 1'b0, 1'b1)));
        rows.push_back(r(1'b0, 1'b1, 8'h12, 8'h34, 1'b0, 1'b0, v(8'h12, 8'h34, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0)));
        rows.push_back(r(1'b1, 1'b1, 8'h12, 8'h34, 1'b0, 1'b0, v(8'h12, 8'h34, 8'h01, 1'b0, 1'b0, 1'b0, 1'b1)));
        rows.push_back(r(1'b1, 1'b1, 8'h12, 8'h34, 1'b0, 1'b0, v(8'h12, 8'h34, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0)));
        rows.push_back(r(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, v(8'h12, 8'h34, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1)));
        foreach (rows[i]) begin
            drive_row(rows[i]);
            exp_q.push_back(rows[i].want);
            @(posedge clk);
            #1;
            expected = exp_q.pop_front();
            tests_run++;
            if (act_24 !== expected) begin
                tests_failed++;
                $display("[TB] FAIL load row %0d: got %h, expected %h", i, act_24, expected);
            end
        end
        clear_inputs();
    endtask

    task automatic test_load_illegal;
        row_t rows[$];
        logic [27:0] expected;
        rows.push_back(r(1'b1, 1'b1, 8'h24, 8'h00, 1'b0, 1'b0, v(8'h12, 8'h34, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0)));
        rows.push_back(r(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, v(8'h12, 8'h34, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1)));
        rows.push_back(r(1'b0, 1'b1, 8'h1A, 8'h00, 1'b1, 1'b0, v(8'h12, 8'h34, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0)));
        rows.push_back(r(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, v(8'h12, 8'h34, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1)));
        rows.push_back(r(1'b0, 1'b1, 8'h12, 8'h60, 1'b0, 1'b1, v(8'h12, 8'h34, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0)));
        rows.push_back(r(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, v(8'h12, 8'h34, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1)));
        foreach (rows[i]) begin
            drive_row(rows[i]);
            exp_q.push_back(rows[i].want);
            @(posedge clk);
            #1;
            expected = exp_q.pop_front();
            tests_run++;
            if (act_24 !== expected) begin
                tests_failed++;
                $display("[TB] FAIL load_illegal row %0d: got %h, expected %h", i, act_24, expected);
            end
        end
        clear_inputs();
    endtask

    task automatic test_inc;
        row_t rows[$];
        logic [27:0] expected;
        rows.push_back(r(1'b0, 1'b1, 8'h10, 8'h58, 1'b0, 1'b0, v(8'h10, 8'h58, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0)));
        for (int i = 1; i <= 59; i++)
            rows.push_back(r(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, v(8'h10, 8'h58, bcd(i), 1'b0, 1'b0, 1'b0, 1'b1)));
        // tick carry and button together move minutes only once
        rows.push_back(r(1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, v(8'h10, 8'h59, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1)));
        for (int i = 1; i <= 59; i++)
            rows.push_back(r(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, v(8'h10, 8'h59, bcd(i), 1'b0, 1'b0, 1'b0, 1'b1)));
        rows.push_back(r(1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, v(8'h10, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1)));
        rows.push_back(r(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, v(8'h11, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1)));
        rows.push_back(r(1'b0, 1'b1, 8'h23, 8'h00, 1'b0, 1'b0, v(8'h23, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0)));
        rows.push_back(r(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, v(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1)));
        rows.push_back(r(1'b0, 1'b1, 8'h11, 8'h59, 1'b0, 1'b0, v(8'h11, 8'h59, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0)));
        for (int i = 1; i <= 59; i++)
            rows.push_back(r(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, v(8'h11, 8'h59, bcd(i), 1'b0, 1'b0, 1'b0, 1'b1)));
        rows.push_back(r(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, v(8'h12, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1)));
        foreach (rows[i]) begin
            drive_row(rows[i]);
            exp_q.push_back(rows[i].want);
            @(posedge clk);
            #1;
            expected = exp_q.pop_front();
            tests_run++;
            if (act_24 !== expected) begin
                tests_failed++;
                $display("[TB] FAIL inc row %0d: got %h, expected %h", i, act_24, expected);
            end
        end
        clear_inputs();
    endtask

    task automatic test_hours12;
        row_t rows[$];
        logic [27:0] expected;
        rows.push_back(r(1'b0, 1'b1, 8'h12, 8'h59, 1'b0, 1'b0, v(8'h12, 8'h59, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0)));
        for (int i = 1; i <= 59; i++)
            rows.push_back(r(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, v(8'h12, 8'h59, bcd(i), 1'b0, 1'b0, 1'b0, 1'b1)));
        rows.push_back(r(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, v(8'h01, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1)));
        rows.push_back(r(1'b0, 1'b1, 8'h11, 8'h59, 1'b0, 1'b0, v(8'h11, 8'h59, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0)));
        for (int i = 1; i <= 59; i++)
            rows.push_back(r(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, v(8'h11, 8'h59, bcd(i), 1'b0, 1'b0, 1'b0, 1'b1)));
        rows.push_back(r(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, v(8'h12, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1)));
        rows.push_back(r(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, v(8'h12, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1)));
        rows.push_back(r(1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, v(8'h12, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0)));
        rows.push_back(r(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, v(8'h12, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1)));
        rows.push_back(r(1'b0, 1'b1, 8'h13, 8'h00, 1'b0, 1'b0, v(8'h12, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0)));
        rows.push_back(r(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, v(8'h01, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1)));
        foreach (rows[i]) begin
            drive_row(rows[i]);
            exp_q.push_back(rows[i].want);
            @(posedge clk);
            #1;
            expected = exp_q.pop_front();
            tests_run++;
            if (act_12 !== expected) begin
                tests_failed++;
                $display("[TB] FAIL hours12 row %0d: got %h, expected %h", i, act_12, expected);
            end
        end
        clear_inputs();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b1;
        clear_inputs();
        test_reset();
        test_rollover();
        test_load();
        test_load_illegal();
        test_inc();
        test_hours12();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
